mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester arbiter for a single-port program/data memory.
//
// A CPU control unit and a host loader share one memory port. A Moore grant
// FSM (IDLE / GCPU / GHOST) hands the port to one requester at a time; ties
// from IDLE go to the side that was not served last. The memory strobe is
// gated combinationally by the holder's request, so an access stops in the
// same cycle its request drops.
//
// Optional feature (macro ARB_TIMEOUT_EN): a 2-bit hold counter forces the
// grant over to the other side after 4 consecutive contended granted cycles.
// Without the macro a holder keeps the grant for as long as its req is high.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_cpu, we_cpu                 CPU request (held for the access), write enable
//   addr_cpu[AW], wdata_cpu[DW]     CPU address / write data
//   req_host, we_host               host loader request, write enable
//   addr_host[AW], wdata_host[DW]   host address / write data
//   gnt_cpu, gnt_host               registered grants (one-hot or zero)
//   mem_en, mem_we                  memory strobe and write enable
//   mem_addr[AW], mem_wdata[DW]     memory address / write data

module mem_arbiter #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_cpu,
  input  logic          we_cpu,
  input  logic [AW-1:0] addr_cpu,
  input  logic [DW-1:0] wdata_cpu,
  input  logic          req_host,
  input  logic          we_host,
  input  logic [AW-1:0] addr_host,
  input  logic [DW-1:0] wdata_host,
  output logic          gnt_cpu,
  output logic          gnt_host,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GCPU  = 2'd1,
    GHOST = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_host;   // 1: host was the last side granted
  logic   timeout;     // holder must yield to a waiting requester

`ifdef ARB_TIMEOUT_EN
  logic [1:0] hold_cnt, hold_cnt_nxt;
  logic       contended;

  // Reaching 3 means this is the 4th consecutive contended cycle.
  assign timeout   = (hold_cnt == 2'd3);
  assign contended = ((state == GCPU) && req_host) || ((state == GHOST) && req_cpu);

  always_comb begin
    hold_cnt_nxt = '0;
    if ((state_nxt == state) && contended)
      hold_cnt_nxt = hold_cnt + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= hold_cnt_nxt;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (req_cpu && req_host) state_nxt = last_host ? GCPU : GHOST;
        else if (req_cpu)        state_nxt = GCPU;
        else if (req_host)       state_nxt = GHOST;
        else                     state_nxt = IDLE;
      end
      GCPU: begin
        if (req_host && (!req_cpu || timeout)) state_nxt = GHOST;
        else if (req_cpu)                      state_nxt = GCPU;
        else                                   state_nxt = IDLE;
      end
      GHOST: begin
        if (req_cpu && (!req_host || timeout)) state_nxt = GCPU;
        else if (req_host)                     state_nxt = GHOST;
        else                                   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_host <= 1'b1;
    end else begin
      state <= state_nxt;
      if ((state_nxt == GCPU) && (state != GCPU))
        last_host <= 1'b0;
      else if ((state_nxt == GHOST) && (state != GHOST))
        last_host <= 1'b1;
    end
  end

  // Outputs: grants decode the state register; the memory port is muxed
  // from the holder and zeroed when nobody holds the grant.
  always_comb begin
    gnt_cpu   = 1'b0;
    gnt_host  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      GCPU: begin
        gnt_cpu   = 1'b1;
        mem_en    = req_cpu;
        mem_we    = we_cpu;
        mem_addr  = addr_cpu;
        mem_wdata = wdata_cpu;
      end
      GHOST: begin
        gnt_host  = 1'b1;
        mem_en    = req_host;
        mem_we    = we_host;
        mem_addr  = addr_host;
        mem_wdata = wdata_host;
      end
      default: ;
    endcase
  end

endmodule
